// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM states and lane/alignment helpers
// for the memory slave and its word array.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_LAST = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_e;

   // Little-endian lane mask; unsupported sizes select no lanes.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lo;
         HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic is_fault(input logic [2:0] size, input logic [1:0] lo);
      return ((size == HSIZE_HALF) && lo[0]) ||
             ((size == HSIZE_WORD) && (lo != 2'b00)) ||
             (size > HSIZE_WORD);
   endfunction

endpackage

// File: rtl/ahb_sram_be.sv
// Word array with per-byte write enables, synchronous write and
// asynchronous read on a shared word address.
module ahb_sram_be #(
   parameter int AW    = 10,
   parameter int DEPTH = 2**AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         always_ff @(posedge clk) begin
            if (we && be[gi]) begin
               lane_mem[addr] <= wdata[gi*8 +: 8];
            end
         end

         assign rdata[gi*8 +: 8] = lane_mem[addr];
      end
   endgenerate

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte-addressable word array with a fixed number
// of wait states per OKAY data phase and a two-cycle ERROR for misalignment.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP,
   output logic        HREADYout
);

   localparam int         WORD_AW = ADDR_WIDTH - 2;
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [WORD_AW-1:0] addr_q, addr_d;
   logic               write_q, write_d;
   logic [3:0]         be_q, be_d;

   logic               accept;
   logic               fault;
   logic               mem_we;
   logic [31:0]        mem_rdata;

   // Burst type, upper address bits and HTRANS[0] carry no information here.
   logic unused_bits;
   assign unused_bits = ^{HBURST, HADDR[31:ADDR_WIDTH], HTRANS[0]};

   always_comb begin
      accept  = HSEL && HREADY && HTRANS[1];
      fault   = is_fault(HSIZE, HADDR[1:0]);
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      be_d    = be_q;
      case (state_q)
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_LAST;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            // IDLE, LAST and ERR2 all end with HREADYout high, so a new
            // address phase can be taken in any of them.
            state_d = ST_IDLE;
            if (accept) begin
               addr_d  = HADDR[ADDR_WIDTH-1:2];
               write_d = HWRITE;
               be_d    = byte_en(HSIZE, HADDR[1:0]);
               if (fault) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_INIT;
               end else begin
                  state_d = ST_LAST;
               end
            end
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         be_q    <= be_d;
      end
   end

   always_comb begin
      HREADYout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
      HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      HRDATA    = ((state_q == ST_LAST) && !write_q) ? mem_rdata : 32'h0;
      mem_we    = (state_q == ST_LAST) && write_q && !HRESET;
   end

   // Read data depends only on the latched address, never on HWDATA.
   ahb_sram_be #(
      .AW (WORD_AW)
   ) u_sram (
      .clk   (HCLK),
      .we    (mem_we),
      .be    (be_q),
      .addr  (addr_q),
      .wdata (HWDATA),
      .rdata (mem_rdata)
   );

endmodule
